alu_scheduler: RTL and testbench

- Shares one serial-protocol ALU (BEGIN/op_code/inbus/outbus/END) between two requesters.
- Arbitrates round-robin and latches each requester's opcode and operands.
- Drives the ALU issue sequence (opcode, operand A, operand B), waits for END and returns the 8-bit result to the winner.
- Sits between client logic and the `alu` instance; the ALU shares the same clk/reset.

---
 rtl/alu_sched_pkg.sv | 21 ++
 rtl/alu_scheduler_if.sv | 35 +++
 rtl/rr_arb2.sv | 16 +
 rtl/alu_scheduler.sv | 140 ++++++++++++++
 tb/tb_alu_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the two-client ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StIssueOp,
    StIssueA,
    StIssueB,
    StWaitEnd,
    StResp,
    StDrain
  } state_e;

endpackage

// File: rtl/alu_scheduler_if.sv
// Client request/response and serial-ALU pins of the scheduler.
// slave: the scheduler's view; master: the clients plus ALU driving the scheduler.
interface alu_scheduler_if import alu_sched_pkg::*; #(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

  logic [1:0]        req_valid;
  logic [1:0]        req_op0;
  logic [1:0]        req_op1;
  logic [DATA_W-1:0] req_a0;
  logic [DATA_W-1:0] req_a1;
  logic [DATA_W-1:0] req_b0;
  logic [DATA_W-1:0] req_b1;
  logic [1:0]        req_ready;
  logic [1:0]        rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              busy;
  logic              alu_begin;
  logic [1:0]        alu_op_code;
  logic [DATA_W-1:0] alu_inbus;
  logic [DATA_W-1:0] alu_outbus;
  logic              alu_end;

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, alu_outbus, alu_end,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, alu_begin, alu_op_code, alu_inbus
  );

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, alu_outbus, alu_end,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, alu_begin, alu_op_code, alu_inbus
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; combinational, the caller owns the last-granted register.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    idx = req[1];
    if (&req) idx = ~last;
    gnt = 2'b00;
    if (|req) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one serial-protocol ALU between two requesters with round-robin arbitration.
// Optional END watchdog enabled by defining ALU_SCHED_TIMEOUT_EN.
module alu_scheduler import alu_sched_pkg::*; #(
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            reset,
  alu_scheduler_if.slave bus
);

  state_e            state_q;
  logic              ptr_q;  // index holding priority when both request
  logic              win_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [1:0]        req_ready_q, rsp_valid_q, alu_op_code_q;
  logic [DATA_W-1:0] rsp_data_q, alu_inbus_q;
  logic              busy_q, alu_begin_q;
  logic [1:0]        gnt;
  logic              idx, last;

  assign last = ~ptr_q;

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .last (last),
    .gnt  (gnt),
    .idx  (idx)
  );

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q;
  logic            rsp_err_q;
  assign bus.rsp_err = rsp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES[0];
  assign bus.rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      win_q         <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      req_ready_q   <= 2'b00;
      rsp_valid_q   <= 2'b00;
      rsp_data_q    <= '0;
      busy_q        <= 1'b0;
      alu_begin_q   <= 1'b0;
      alu_op_code_q <= 2'b00;
      alu_inbus_q   <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      unique case (state_q)
        StIdle: begin
          if (|bus.req_valid) begin
            req_ready_q   <= gnt;
            win_q         <= idx;
            ptr_q         <= ~idx;
            a_q           <= idx ? bus.req_a1 : bus.req_a0;
            b_q           <= idx ? bus.req_b1 : bus.req_b0;
            alu_op_code_q <= idx ? bus.req_op1 : bus.req_op0;
            alu_begin_q   <= 1'b1;
            alu_inbus_q   <= '0;
            busy_q        <= 1'b1;
            state_q       <= StIssueOp;
          end
        end
        StIssueOp: begin
          alu_inbus_q <= a_q;
          state_q     <= StIssueA;
        end
        StIssueA: begin
          alu_begin_q <= 1'b0;
          alu_inbus_q <= b_q;
          state_q     <= StIssueB;
        end
        StIssueB: begin
          state_q <= StWaitEnd;
`ifdef ALU_SCHED_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        StWaitEnd: begin
          if (bus.alu_end) begin
            rsp_data_q         <= bus.alu_outbus;
            rsp_valid_q[win_q] <= 1'b1;
            state_q            <= StResp;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data_q         <= '0;
            rsp_err_q          <= 1'b1;
            rsp_valid_q[win_q] <= 1'b1;
            state_q            <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StResp: begin
          state_q <= StDrain;
`ifdef ALU_SCHED_TIMEOUT_EN
          // A timed-out ALU never raised END, so there is nothing to drain.
          rsp_err_q <= 1'b0;
          if (rsp_err_q) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
`endif
        end
        StDrain: begin
          if (!bus.alu_end) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.busy        = busy_q;
  assign bus.alu_begin   = alu_begin_q;
  assign bus.alu_op_code = alu_op_code_q;
  assign bus.alu_inbus   = alu_inbus_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: table of single transactions plus arbitration,
// END-hold, mid-operation reset and (with ALU_SCHED_TIMEOUT_EN) watchdog sequences.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_scheduler_if #(.DATA_W(8)) bus ();

  alu_scheduler #(
    .DATA_W         (8),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Stub serial ALU: captures op, A, B from the pins and answers after end_lat cycles,
  // holding END for end_hold cycles.
  int         stub_st, stub_cnt, seq_err_cnt;
  logic [1:0] s_op;
  logic [7:0] s_a, s_b;
  int         end_lat, end_hold;
  bit         never_end, flush;

  function automatic logic [7:0] calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_ADD:  return 8'(a + b);
      OP_SUB:  return 8'(a - b);
      OP_MUL:  return 8'(a * b);
      default: return (b == 8'd0) ? 8'hFF : 8'(a / b);
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_st        <= 0;
      stub_cnt       <= 0;
      bus.alu_end    <= 1'b0;
      bus.alu_outbus <= 8'h00;
    end else if (flush) begin
      stub_st     <= 0;
      bus.alu_end <= 1'b0;
    end else begin
      case (stub_st)
        0: if (bus.alu_begin) begin
          s_op    <= bus.alu_op_code;
          stub_st <= 1;
          if (bus.alu_inbus != 8'h00) seq_err_cnt <= seq_err_cnt + 1;
        end
        1: begin
          s_a     <= bus.alu_inbus;
          stub_st <= 2;
          if (!bus.alu_begin) seq_err_cnt <= seq_err_cnt + 1;
        end
        2: begin
          s_b      <= bus.alu_inbus;
          stub_st  <= 3;
          stub_cnt <= end_lat;
          if (bus.alu_begin) seq_err_cnt <= seq_err_cnt + 1;
        end
        3: if (!never_end) begin
          if (stub_cnt == 0) begin
            bus.alu_end    <= 1'b1;
            bus.alu_outbus <= calc(s_op, s_a, s_b);
            stub_cnt       <= end_hold - 1;
            stub_st        <= 4;
          end else stub_cnt <= stub_cnt - 1;
        end
        4: if (stub_cnt == 0) begin
          bus.alu_end <= 1'b0;
          stub_st     <= 0;
        end else stub_cnt <= stub_cnt - 1;
        default: stub_st <= 0;
      endcase
    end
  end

  // Observation state, updated only by step() on the falling edge.
  int         cyc, n_gnt, n_rsp, outstanding, gnt_cyc, fall_cyc;
  int         onehot_err, pend_err, end_grant_err;
  int         rdy_cnt[2];
  int         gnt_log[$];
  int         dat_log[$];
  logic [1:0] last_rsp_valid;
  logic [7:0] last_rsp_data;
  logic       last_rsp_err, end_prev;
  bit         drop_on_ready;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (end_prev && !bus.alu_end) fall_cyc = cyc;
    end_prev = bus.alu_end;
    if (bus.req_ready != 2'b00) begin
      if (!$onehot(bus.req_ready)) onehot_err++;
      if (outstanding != 0) pend_err++;
      if (bus.alu_end) end_grant_err++;
      gnt_log.push_back(int'(bus.req_ready[1]));
      rdy_cnt[bus.req_ready[1]]++;
      n_gnt++;
      gnt_cyc = cyc;
      outstanding++;
      if (drop_on_ready) begin
        // Scramble operands after acceptance; the latched copy must be used.
        if (bus.req_ready[0]) begin
          bus.req_valid[0] = 1'b0;
          bus.req_a0 = ~bus.req_a0; bus.req_b0 = ~bus.req_b0; bus.req_op0 = ~bus.req_op0;
        end
        if (bus.req_ready[1]) begin
          bus.req_valid[1] = 1'b0;
          bus.req_a1 = ~bus.req_a1; bus.req_b1 = ~bus.req_b1; bus.req_op1 = ~bus.req_op1;
        end
      end
    end
    if (bus.rsp_valid != 2'b00) begin
      if (!$onehot(bus.rsp_valid)) onehot_err++;
      last_rsp_valid = bus.rsp_valid;
      last_rsp_data  = bus.rsp_data;
      last_rsp_err   = bus.rsp_err;
      dat_log.push_back(int'(bus.rsp_data));
      n_rsp++;
      outstanding--;
    end
  endtask

  task automatic issue(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    if (idx == 0) begin
      bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b;
    end else begin
      bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b;
    end
    bus.req_valid[idx] = 1'b1;
  endtask

  task automatic wait_rsps(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (n_rsp >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      if (!bus.busy && !bus.alu_end) ok = 1'b1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_rsp_data"}, 32'(bus.rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(bus.rsp_err), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_alu_begin"}, 32'(bus.alu_begin), 0);
    check({tag, "_alu_op_code"}, 32'(bus.alu_op_code), 0);
    check({tag, "_alu_inbus"}, 32'(bus.alu_inbus), 0);
  endtask

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [7:0] a, b;
    int         lat, hold;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    int base, lat;

    tbl[0] = '{0, OP_ADD, 8'd3,   8'd2,  0, 1, 8'd5};
    tbl[1] = '{1, OP_SUB, 8'd9,   8'd1,  2, 1, 8'd8};
    tbl[2] = '{1, OP_MUL, 8'd7,   8'd3,  1, 3, 8'd21};
    tbl[3] = '{0, OP_DIV, 8'd200, 8'd7,  0, 2, 8'd28};
    tbl[4] = '{0, OP_SUB, 8'd3,   8'd5,  3, 1, 8'hFE};
    tbl[5] = '{1, OP_MUL, 8'd20,  8'd13, 0, 1, 8'd4};
    tbl[6] = '{1, OP_ADD, 8'd255, 8'd1,  0, 1, 8'd0};

    seq_err_cnt = 0; end_lat = 0; end_hold = 1; never_end = 1'b0; flush = 1'b0;
    drop_on_ready = 1'b1; end_prev = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_op0 = 2'b00; bus.req_op1 = 2'b00;
    bus.req_a0 = 8'h00; bus.req_a1 = 8'h00; bus.req_b0 = 8'h00; bus.req_b1 = 8'h00;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;

    // Single transactions from the table.
    foreach (tbl[i]) begin
      end_lat  = tbl[i].lat;
      end_hold = tbl[i].hold;
      base     = n_rsp;
      issue(tbl[i].idx, tbl[i].op, tbl[i].a, tbl[i].b);
      wait_rsps(base + 1, 60, ok);
      check("rsp_seen", 32'(ok), 1);
      check("rsp_valid", 32'(last_rsp_valid), (tbl[i].idx == 1) ? 2 : 1);
      check("rsp_data", 32'(last_rsp_data), 32'(tbl[i].exp));
      check("rsp_err", 32'(last_rsp_err), 0);
      check("alu_op", 32'(s_op), 32'(tbl[i].op));
      check("alu_a", 32'(s_a), 32'(tbl[i].a));
      check("alu_b", 32'(s_b), 32'(tbl[i].b));
      wait_idle(ok);
      check("idle_after_txn", 32'(ok), 1);
    end

    // END held high for 3 cycles while another request is already pending.
    end_lat = 0; end_hold = 3; base = n_rsp;
    dat_log.delete();
    issue(1, OP_MUL, 8'd7, 8'd3);
    wait_rsps(base + 1, 60, ok);
    issue(0, OP_ADD, 8'd1, 8'd1);
    wait_rsps(base + 2, 60, ok);
    check("hold_two_rsps", 32'(ok), 1);
    check("hold_mul_data", 32'(dat_log[0]), 21);
    check("hold_grant_after_fall", 32'(gnt_cyc > fall_cyc), 1);
    wait_idle(ok);
    check("hold_rsp_count", 32'(dat_log.size()), 2);
    end_hold = 1;

    // Reset while waiting for END; req 0 granted last so the pointer would favour req 1.
    never_end = 1'b1; base = n_rsp;
    issue(0, OP_MUL, 8'd1, 8'd1);
    for (int i = 0; i < 20 && stub_st != 3; i++) step();
    repeat (3) step();
    check("midop_busy", 32'(bus.busy), 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("midop_reset");
    @(negedge clk);
    reset = 1'b0; never_end = 1'b0; outstanding = 0;
    repeat (10) step();
    check("midop_no_rsp", 32'(n_rsp), 32'(base));

    // Simultaneous requests after reset: req 0 first.
    gnt_log.delete(); dat_log.delete(); rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    issue(0, OP_ADD, 8'd10, 8'd4);
    issue(1, OP_SUB, 8'd9, 8'd1);
    wait_rsps(n_rsp + 2, 100, ok);
    check("simul_two_rsps", 32'(ok), 1);
    wait_idle(ok);
    check("simul_first_gnt", 32'(gnt_log[0]), 0);
    check("simul_second_gnt", 32'(gnt_log[1]), 1);
    check("simul_data0", 32'(dat_log[0]), 14);
    check("simul_data1", 32'(dat_log[1]), 8);
    check("simul_ready0_once", 32'(rdy_cnt[0]), 1);
    check("simul_ready1_once", 32'(rdy_cnt[1]), 1);

    // Fairness: both requests held for four transactions.
    drop_on_ready = 1'b0;
    gnt_log.delete(); dat_log.delete();
    issue(0, OP_ADD, 8'd1, 8'd2);
    issue(1, OP_MUL, 8'd2, 8'd3);
    wait_rsps(n_rsp + 4, 200, ok);
    bus.req_valid = 2'b00;
    check("fair_four_rsps", 32'(ok), 1);
    repeat (10) step();
    check("fair_gnt_count", 32'(gnt_log.size()), 4);
    for (int i = 0; i < 4; i++) begin
      check("fair_gnt_order", 32'(gnt_log[i]), 32'(i % 2));
      check("fair_data", 32'(dat_log[i]), (i % 2 == 0) ? 3 : 6);
    end
    drop_on_ready = 1'b1;

`ifdef ALU_SCHED_TIMEOUT_EN
    // Watchdog: ALU never answers.
    never_end = 1'b1; base = n_rsp;
    issue(1, OP_ADD, 8'd5, 8'd5);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      step();
      if (bus.req_ready[1]) lat = 0;
    end
    for (int i = 0; i < 40 && n_rsp == base; i++) begin
      step();
      lat++;
    end
    check("to_latency", 32'(lat), 11);
    check("to_rsp_valid", 32'(last_rsp_valid), 2);
    check("to_rsp_data", 32'(last_rsp_data), 0);
    check("to_rsp_err", 32'(last_rsp_err), 1);
    step();
    check("to_idle_no_drain", 32'(bus.busy), 0);
    flush = 1'b1; step(); flush = 1'b0; never_end = 1'b0;
    issue(0, OP_SUB, 8'd9, 8'd4);
    wait_rsps(n_rsp + 1, 60, ok);
    check("to_next_rsp", 32'(ok), 1);
    check("to_next_data", 32'(last_rsp_data), 5);
    check("to_next_err", 32'(last_rsp_err), 0);
    wait_idle(ok);
`endif

    check("onehot_violations", 32'(onehot_err), 0);
    check("grant_while_pending", 32'(pend_err), 0);
    check("grant_while_end_high", 32'(end_grant_err), 0);
    check("alu_pin_sequence", 32'(seq_err_cnt), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
